if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues fetches on the instruction-memory req/ack port and fills
//  the IF/ID register (valid, pc, instr). It consumes the branch unit's registered redirect
//  (use_branch/branch_out/flush), handles ID backpressure (stall) and discards in-flight fetches on redirect.
// PARAMETERS
//  PC_ADDR     32'h8000_0000  reset PC / first fetch address
//  ADDR_WIDTH  32             address width
//  DATA_WIDTH  32             instruction width
//  NOP_INSTR   32'h0000_0013  value driven on if_instr_o while invalid (addi x0,x0,0)
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-high
//  use_branch   in   1           1-cycle redirect pulse from branch unit
//  branch_out   in   ADDR_WIDTH  redirect target, sampled when use_branch=1
//  flush        in   1           invalidate IF/ID contents and skid entry
//  stall        in   1           ID cannot accept; hold IF/ID when valid
//  imem_req_o   out  1           fetch request; held until imem_ack_i
//  imem_addr_o  out  ADDR_WIDTH  fetch address; stable while req high
//  imem_ack_i   in   1           fetch done; imem_data_i valid this cycle (may be same cycle as req)
//  imem_data_i  in   DATA_WIDTH  fetched instruction
//  if_valid_o   out  1           IF/ID holds a live instruction
//  if_pc_o      out  ADDR_WIDTH  PC of if_instr_o
//  if_instr_o   out  DATA_WIDTH  instruction to ID
// BEHAVIOUR
//  Reset (async): state=RUN, pc=PC_ADDR, imem_req_o=0, if_valid_o=0, if_pc_o=PC_ADDR, if_instr_o=NOP_INSTR,
//   skid empty. imem_req_o rises the first clk edge after reset deasserts.
//  Registers: pc (address of current/next fetch), pend_pc (target held in DROP), skid_{instr,pc}.
//  imem_req_o = (state==RUN)|(state==DROP); imem_addr_o = pc; never changes while req high and no ack.
//  slot_free = !if_valid_o | !stall. Redirect = use_branch (highest priority; beats stall and ack).
//  RUN:
//   ack & !redirect & slot_free  -> IF/ID<={1,pc,data}; pc<=pc+4; stay RUN (1 instr/cycle w/ 0-wait mem).
//   ack & !redirect & !slot_free -> skid<={pc,data}; pc<=pc+4; -> SKID (req low).
//   redirect & ack               -> data discarded; pc<=branch_out; stay RUN.
//   redirect & !ack              -> pend_pc<=branch_out; -> DROP (req held at old pc).
//  SKID: redirect -> skid cleared, pc<=branch_out, -> RUN. else !stall -> IF/ID<=skid, -> RUN.
//  DROP: ack -> data discarded, pc<=pend_pc, -> RUN; second redirect updates pend_pc (last wins);
//   redirect & ack same cycle -> pc<=branch_out, -> RUN.
//  flush or use_branch: if_valid_o<=0, if_instr_o<=NOP_INSTR next edge regardless of stall.
//  flush without use_branch: also clears skid (SKID -> RUN), pc unchanged.
//  IF/ID holds when if_valid_o & stall & no flush/redirect; never loses or duplicates an instruction.
//  Arithmetic: pc+4 modulo 2^ADDR_WIDTH (FFFF_FFFC -> 0000_0000); branch_out[1:0] forced to 0.
//  Redirect penalty: target fetch addr on imem_addr_o the cycle after use_branch (RUN) or after ack (DROP).
//  Reset mid-transaction: immediate return to reset values; outstanding fetch abandoned, no data kept.
// STRUCTURE
//  Shared pipeline package: fetch_state_t enum {RUN,SKID,DROP}, INSTR_BYTES=4, NOP_INSTR constant,
//  if_id_t struct {valid,pc,instr} for IF/ID. Single module; skid entry inline, no sub-module.
// TESTING
//  1 Reset release, ack every cycle, stall=0 -> addr 8000_0000,_0004,_0008...; if_pc_o follows, 1 instr/cycle.
//  2 if_valid=1, stall=1, ack for 8000_0004 -> SKID, req low; stall=0 -> if_pc_o=8000_0004, next req 8000_0008.
//  3 Req 8000_0008 pending, use_branch target 8000_0100 -> addr stays 8000_0008 until ack, data dropped,
//    next addr 8000_0100, if_valid_o=0 until its ack.
//  4 use_branch same cycle as ack (target 8000_0200) and use_branch in SKID w/ stall=1 -> no stale instr
//    ever valid; next fetch 8000_0200.
//  5 Redirect to FFFF_FFFC (branch_out=FFFF_FFFF) -> fetches FFFF_FFFC then 0000_0000.
//  6 reset asserted mid-DROP -> all outputs at reset values same cycle; restart fetch at 8000_0000.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID boundary.
package if_fetch_stage_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        StRun,
        StSkid,
        StDrop
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack port and fills the IF/ID register,
// with a one-entry skid for ID backpressure and a drop state for redirects during a pending fetch.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(if_fetch_stage_pkg::NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  use_branch,
    input  logic [ADDR_WIDTH-1:0] branch_out,
    input  logic                  flush,
    input  logic                  stall,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    output logic                  if_valid_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_instr_o
);

    fetch_state_t          state_q, state_d;
    logic                  started_q;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;

    logic                  ack_v;
    logic                  slot_free;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc_next;

    // started_q keeps req low for the first cycle out of reset.
    assign imem_req_o  = started_q && (state_q == StRun || state_q == StDrop);
    assign imem_addr_o = pc_q;
    assign ack_v       = imem_ack_i && imem_req_o;
    assign slot_free   = !valid_q || !stall;
    assign target      = {branch_out[ADDR_WIDTH-1:2], 2'b00};
    assign pc_next     = pc_q + ADDR_WIDTH'(INSTR_BYTES);

    assign if_valid_o  = valid_q;
    assign if_pc_o     = out_pc_q;
    assign if_instr_o  = instr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        valid_d      = valid_q;
        out_pc_d     = out_pc_q;
        instr_d      = instr_q;

        // ID takes the current instruction whenever it is not stalled.
        if (valid_q && !stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        unique case (state_q)
            StRun: begin
                if (use_branch) begin
                    if (ack_v || !imem_req_o) begin
                        pc_d = target;
                    end else begin
                        pend_pc_d = target;
                        state_d   = StDrop;
                    end
                end else if (ack_v && !flush) begin
                    if (slot_free) begin
                        valid_d  = 1'b1;
                        out_pc_d = pc_q;
                        instr_d  = imem_data_i;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_data_i;
                        state_d      = StSkid;
                    end
                    pc_d = pc_next;
                end
            end
            StSkid: begin
                if (use_branch) begin
                    pc_d    = target;
                    state_d = StRun;
                end else if (flush) begin
                    state_d = StRun;
                end else if (!stall) begin
                    valid_d  = 1'b1;
                    out_pc_d = skid_pc_q;
                    instr_d  = skid_instr_q;
                    state_d  = StRun;
                end
            end
            StDrop: begin
                if (ack_v) begin
                    pc_d    = use_branch ? target : pend_pc_q;
                    state_d = StRun;
                end else if (use_branch) begin
                    pend_pc_d = target;
                end
            end
            default: state_d = StRun;
        endcase

        if (flush || use_branch) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            started_q    <= 1'b0;
            pc_q         <= PC_ADDR;
            pend_pc_q    <= PC_ADDR;
            skid_pc_q    <= PC_ADDR;
            skid_instr_q <= NOP_INSTR;
            valid_q      <= 1'b0;
            out_pc_q     <= PC_ADDR;
            instr_q      <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            started_q    <= 1'b1;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            valid_q      <= valid_d;
            out_pc_q     <= out_pc_d;
            instr_q      <= instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a vector table for the main fetch/stall/redirect flow,
// then hand-written sequences for DROP retargeting and asynchronous reset mid-DROP.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        use_branch;
    logic [31:0] branch_out;
    logic        flush;
    logic        stall;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_data_i = mem_word(imem_addr_o);

    if_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .use_branch  (use_branch),
        .branch_out  (branch_out),
        .flush       (flush),
        .stall       (stall),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .if_valid_o  (if_valid_o),
        .if_pc_o     (if_pc_o),
        .if_instr_o  (if_instr_o)
    );

    typedef struct packed {
        logic        ack;
        logic        stl;
        logic        ub;
        logic        fl;
        logic [31:0] bo;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic ack, input logic stl, input logic ub, input logic fl,
                                input logic [31:0] bo, input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.stl = stl; v.ub = ub; v.fl = fl; v.bo = bo;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc);
        chk({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, e_req});
        chk({tag, ".addr"}, imem_addr_o, e_addr);
        chk({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, e_valid});
        chk({tag, ".pc"}, if_pc_o, e_pc);
        chk({tag, ".instr"}, if_instr_o, e_valid ? mem_word(e_pc) : NOP);
    endtask

    task automatic drive(input logic ack, input logic stl, input logic ub, input logic fl,
                         input logic [31:0] bo);
        imem_ack_i = ack; stall = stl; use_branch = ub; flush = fl; branch_out = bo;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [24];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h8000_0000, 0, 32'h8000_0000);
        tbl[1]  = mk(1, 0, 0, 0, 32'h0,         1, 32'h8000_0000, 0, 32'h8000_0000);
        tbl[2]  = mk(1, 1, 0, 0, 32'h0,         1, 32'h8000_0004, 1, 32'h8000_0000);
        tbl[3]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h8000_0008, 1, 32'h8000_0000);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h8000_0008, 1, 32'h8000_0000);
        tbl[5]  = mk(0, 0, 1, 0, 32'h8000_0100, 1, 32'h8000_0008, 1, 32'h8000_0004);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h8000_0008, 0, 32'h8000_0004);
        tbl[7]  = mk(1, 0, 0, 0, 32'h0,         1, 32'h8000_0008, 0, 32'h8000_0004);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h8000_0100, 0, 32'h8000_0004);
        tbl[9]  = mk(1, 0, 0, 0, 32'h0,         1, 32'h8000_0100, 0, 32'h8000_0004);
        tbl[10] = mk(1, 0, 1, 0, 32'h8000_0200, 1, 32'h8000_0104, 1, 32'h8000_0100);
        tbl[11] = mk(1, 0, 0, 0, 32'h0,         1, 32'h8000_0200, 0, 32'h8000_0100);
        tbl[12] = mk(1, 1, 0, 0, 32'h0,         1, 32'h8000_0204, 1, 32'h8000_0200);
        tbl[13] = mk(0, 1, 1, 0, 32'h8000_0300, 0, 32'h8000_0208, 1, 32'h8000_0200);
        tbl[14] = mk(0, 1, 0, 0, 32'h0,         1, 32'h8000_0300, 0, 32'h8000_0200);
        tbl[15] = mk(1, 0, 1, 0, 32'hFFFF_FFFF, 1, 32'h8000_0300, 0, 32'h8000_0200);
        tbl[16] = mk(1, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h8000_0200);
        tbl[17] = mk(1, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
        tbl[18] = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000);
        tbl[19] = mk(1, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0000_0000);
        tbl[20] = mk(1, 1, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0004);
        tbl[21] = mk(0, 1, 0, 1, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0004);
        tbl[22] = mk(1, 0, 0, 0, 32'h0,         1, 32'h0000_000C, 0, 32'h0000_0004);
        tbl[23] = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_0010, 1, 32'h0000_000C);

        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        tick();
        tick();
        chk_outs("reset", 0, 32'h8000_0000, 0, 32'h8000_0000);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].ack, tbl[i].stl, tbl[i].ub, tbl[i].fl, tbl[i].bo);
            chk_outs($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                     tbl[i].e_pc);
            tick();
        end

        // Two redirects while the fetch is pending: the later target wins.
        drive(0, 0, 1, 0, 32'h0000_0500);
        chk_outs("drop0", 1, 32'h0000_0010, 0, 32'h0000_000C);
        tick();
        drive(0, 0, 1, 0, 32'h0000_0601);
        chk_outs("drop1", 1, 32'h0000_0010, 0, 32'h0000_000C);
        tick();
        drive(1, 0, 0, 0, 32'h0);
        chk_outs("drop2", 1, 32'h0000_0010, 0, 32'h0000_000C);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        chk_outs("drop3", 1, 32'h0000_0600, 0, 32'h0000_000C);
        tick();

        // Enter DROP again, then hit reset asynchronously in the middle of the cycle.
        drive(0, 0, 1, 0, 32'h0000_0700);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        chk_outs("predrop", 1, 32'h0000_0600, 0, 32'h0000_000C);
        #2 reset = 1'b1;
        #1 chk_outs("asyncrst", 0, 32'h8000_0000, 0, 32'h8000_0000);
        tick();
        reset = 1'b0;
        chk_outs("rel0", 0, 32'h8000_0000, 0, 32'h8000_0000);
        tick();
        drive(1, 0, 0, 0, 32'h0);
        chk_outs("rel1", 1, 32'h8000_0000, 0, 32'h8000_0000);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        chk_outs("rel2", 1, 32'h8000_0004, 1, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
